// File: rtl/mc68040_bus_initiator.sv
// MC68040-style single-transfer bus master: arbitrate, address phase, wait for TACKn/TEAn.
// Optional DATA-phase watchdog enabled by `define MASTER_TIMEOUT_EN.
//   state   | meaning
//   S_IDLE  | no transfer, waiting for REQ
//   S_ARB   | BRn asserted, waiting for BGn low with bus not busy
//   S_ADDR  | TSn asserted for one cycle, address phase
//   S_DATA  | waiting for termination
//   S_RETRY | bus released after retry termination
//   S_END   | DONE pulse, bus released
module mc68040_bus_initiator #(
  parameter int RETRY_MAX = 3
`ifdef MASTER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        CLK40,
  input  logic        RESETn,
  input  logic        REQ,
  input  logic        REQ_RnW,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic [1:0]  REQ_SIZ,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic        BRn,
  input  logic        BGn,
  input  logic        BBn_IN,
  output logic        BBn_OUT,
  output logic        BB_OE,
  output logic        BUS_OE,
  output logic [31:0] A_OUT,
  output logic        RnW_OUT,
  output logic [1:0]  SIZ_OUT,
  output logic [1:0]  TT_OUT,
  output logic [2:0]  TM_OUT,
  output logic        TSn_OUT,
  output logic        TIPn_OUT,
  output logic [31:0] D_OUT,
  output logic        D_OE,
  input  logic [31:0] D_IN,
  input  logic        TACKn,
  input  logic        TEAn
);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ADDR, S_DATA, S_RETRY, S_END} state_t;

  localparam logic [7:0] RETRY_LIM = 8'(RETRY_MAX);

  state_t      state_q, state_d;
  logic        brn_q, brn_d, bb_oe_q, bb_oe_d, bbn_q, bbn_d;
  logic        bus_oe_q, bus_oe_d, d_oe_q, d_oe_d, tsn_q, tsn_d, tipn_q, tipn_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d, rnw_q, rnw_d;
  logic [31:0] rdata_q, rdata_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]  siz_q, siz_d;
  logic [7:0]  retry_q, retry_d;
  logic        go_end, go_retry;
`ifdef MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q, tmo_d;
`endif

  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      state_q  <= S_IDLE;
      brn_q    <= 1'b1;
      bb_oe_q  <= 1'b0;
      bbn_q    <= 1'b1;
      bus_oe_q <= 1'b0;
      d_oe_q   <= 1'b0;
      tsn_q    <= 1'b1;
      tipn_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rnw_q    <= 1'b1;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      siz_q    <= '0;
      retry_q  <= '0;
`ifdef MASTER_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      brn_q    <= brn_d;
      bb_oe_q  <= bb_oe_d;
      bbn_q    <= bbn_d;
      bus_oe_q <= bus_oe_d;
      d_oe_q   <= d_oe_d;
      tsn_q    <= tsn_d;
      tipn_q   <= tipn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rnw_q    <= rnw_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      siz_q    <= siz_d;
      retry_q  <= retry_d;
`ifdef MASTER_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    brn_d    = brn_q;
    bb_oe_d  = bb_oe_q;
    bbn_d    = bbn_q;
    bus_oe_d = bus_oe_q;
    d_oe_d   = d_oe_q;
    tsn_d    = tsn_q;
    tipn_d   = tipn_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    rnw_d    = rnw_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    siz_d    = siz_q;
    retry_d  = retry_q;
    go_end   = 1'b0;
    go_retry = 1'b0;
`ifdef MASTER_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        bb_oe_d = 1'b0;
        retry_d = '0;
        if (REQ) begin
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
          siz_d   = REQ_SIZ;
          rnw_d   = REQ_RnW;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          brn_d   = 1'b0;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (!BGn && BBn_IN) begin
          tsn_d    = 1'b0;
          tipn_d   = 1'b0;
          bus_oe_d = 1'b1;
          bb_oe_d  = 1'b1;
          bbn_d    = 1'b0;
          brn_d    = 1'b1;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        tsn_d   = 1'b1;
        d_oe_d  = !rnw_q;
`ifdef MASTER_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = S_DATA;
      end
      S_DATA: begin
        if (!TACKn && TEAn) begin
          go_end = 1'b1;
          err_d  = 1'b0;
          if (rnw_q) rdata_d = D_IN;
        end else if (TACKn && !TEAn) begin
          go_end = 1'b1;
          err_d  = 1'b1;
        end else if (!TACKn && !TEAn) begin
          if (retry_q < RETRY_LIM) begin
            go_retry = 1'b1;
            retry_d  = retry_q + 8'd1;
          end else begin
            go_end = 1'b1;
            err_d  = 1'b1;
          end
        end
`ifdef MASTER_TIMEOUT_EN
        // a real termination in the same cycle wins over the watchdog
        else if (tmo_q == TMO_LAST) begin
          go_end = 1'b1;
          err_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      S_RETRY: begin
        brn_d   = 1'b0;
        bb_oe_d = 1'b0;
        state_d = S_ARB;
      end
      S_END: begin
        bb_oe_d = 1'b0;
        retry_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (go_end || go_retry) begin
      tipn_d   = 1'b1;
      bbn_d    = 1'b1;
      bus_oe_d = 1'b0;
      d_oe_d   = 1'b0;
    end
    if (go_retry) state_d = S_RETRY;
    if (go_end) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = S_END;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign RDATA    = rdata_q;
  assign BRn      = brn_q;
  assign BBn_OUT  = bbn_q;
  assign BB_OE    = bb_oe_q;
  assign BUS_OE   = bus_oe_q;
  assign A_OUT    = addr_q;
  assign RnW_OUT  = rnw_q;
  assign SIZ_OUT  = siz_q;
  assign TT_OUT   = 2'b00;
  assign TM_OUT   = 3'b001;
  assign TSn_OUT  = tsn_q;
  assign TIPn_OUT = tipn_q;
  assign D_OUT    = wdata_q;
  assign D_OE     = d_oe_q;

endmodule

// File: tb/tb_mc68040_bus_initiator.sv
// Bench for mc68040_bus_initiator: per-cycle expected timeline built from transfer rules.
module tb_mc68040_bus_initiator;
  localparam int RMAX = 3;
  localparam int TMO  = 8;

  logic        clk = 0, rst_n = 0;
  logic        req = 0, req_rnw = 1;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0]  req_siz = 0;
  logic        busy, done, err, brn, bbn_out, bb_oe, bus_oe, rnw_out, tsn, tipn, d_oe;
  logic [31:0] rdata, a_out, d_out;
  logic [1:0]  siz_out, tt_out;
  logic [2:0]  tm_out;
  logic        bgn = 1, bbn_in = 1, tackn = 1, tean = 1;
  logic [31:0] d_in = 0;

  mc68040_bus_initiator #(
    .RETRY_MAX(RMAX)
`ifdef MASTER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .CLK40(clk), .RESETn(rst_n), .REQ(req), .REQ_RnW(req_rnw), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .REQ_SIZ(req_siz), .BUSY(busy), .DONE(done), .ERR(err),
    .RDATA(rdata), .BRn(brn), .BGn(bgn), .BBn_IN(bbn_in), .BBn_OUT(bbn_out), .BB_OE(bb_oe),
    .BUS_OE(bus_oe), .A_OUT(a_out), .RnW_OUT(rnw_out), .SIZ_OUT(siz_out), .TT_OUT(tt_out),
    .TM_OUT(tm_out), .TSn_OUT(tsn), .TIPn_OUT(tipn), .D_OUT(d_out), .D_OE(d_oe),
    .D_IN(d_in), .TACKn(tackn), .TEAn(tean)
  );

  always #5 clk = ~clk;

  // {BRn, BB_OE, BBn_OUT, BUS_OE, D_OE, TSn, TIPn, BUSY, DONE}
  localparam logic [8:0] V_IDLE  = 9'b1_0_1_0_0_1_1_0_0;
  localparam logic [8:0] V_ARB   = 9'b0_0_1_0_0_1_1_1_0;
  localparam logic [8:0] V_ADDR  = 9'b1_1_0_1_0_0_0_1_0;
  localparam logic [8:0] V_DATAR = 9'b1_1_0_1_0_1_0_1_0;
  localparam logic [8:0] V_DATAW = 9'b1_1_0_1_1_1_0_1_0;
  localparam logic [8:0] V_RETRY = 9'b1_1_1_0_0_1_1_1_0;
  localparam logic [8:0] V_END   = 9'b1_1_1_0_0_1_1_0_1;
  localparam int T_TACK = 0, T_TEA = 1, T_BOTH = 2;

  typedef struct {
    logic bgn, bbn_in, tackn, tean;
    logic [31:0] din;
    logic [8:0] ctrl;
    logic chk_addr, chk_dout, chk_end;
  } cyc_t;

  cyc_t        tl[$];
  int          errs = 0, checks = 0;
  logic        exp_err, exp_rd_valid;
  logic [31:0] exp_rdata;
  int          g[4], w[4], tm[4];

  wire [8:0] ctrl_obs = {brn, bb_oe, bbn_out, bus_oe, d_oe, tsn, tipn, busy, done};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic cyc_t idle_c();
    cyc_t c;
    c.bgn = 1; c.bbn_in = 1; c.tackn = 1; c.tean = 1; c.din = $urandom;
    c.ctrl = V_IDLE; c.chk_addr = 0; c.chk_dout = 0; c.chk_end = 0;
    return c;
  endfunction

  // Expected cycle-by-cycle picture of one request: per attempt g ARB waits, one ADDR
  // cycle, w DATA wait cycles, then the termination tm.
  task automatic build(input bit rnw);
    cyc_t c;
    int   ndata;
    bit   tmo;
    tl.delete();
    exp_rd_valid = 0;
    exp_err = 0;
    exp_rdata = 0;
    for (int a = 0; a < 4; a++) begin
      for (int k = 0; k <= g[a]; k++) begin
        c = idle_c();
        c.ctrl = V_ARB;
        if (k == g[a]) c.bgn = 0;
        else if ($urandom_range(1) == 1) begin c.bgn = 0; c.bbn_in = 0; end
        else c.bbn_in = 1'($urandom_range(1));
        tl.push_back(c);
      end
      c = idle_c(); c.ctrl = V_ADDR; c.chk_addr = 1; tl.push_back(c);
      ndata = w[a] + 1;
      tmo = 0;
`ifdef MASTER_TIMEOUT_EN
      if (ndata > TMO) begin ndata = TMO; tmo = 1; end
`endif
      for (int k = 0; k < ndata; k++) begin
        c = idle_c();
        c.ctrl = rnw ? V_DATAR : V_DATAW;
        c.chk_dout = !rnw;
        if (k == ndata - 1 && !tmo) begin
          c.tackn = (tm[a] == T_TEA);
          c.tean  = (tm[a] == T_TACK);
          exp_rdata = c.din;
        end
        tl.push_back(c);
      end
      if (!tmo && tm[a] == T_BOTH && a < RMAX) begin
        c = idle_c(); c.ctrl = V_RETRY; tl.push_back(c);
        continue;
      end
      exp_err = tmo || tm[a] != T_TACK;
      exp_rd_valid = rnw && !exp_err;
      c = idle_c(); c.ctrl = V_END; c.chk_end = 1; tl.push_back(c);
      c = idle_c(); tl.push_back(c);
      break;
    end
  endtask

  task automatic run(input bit rnw, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] siz);
    build(rnw);
    @(negedge clk);
    req = 1; req_rnw = rnw; req_addr = addr; req_wdata = wdata; req_siz = siz;
    bgn = 1; bbn_in = 1; tackn = 1; tean = 1;
    for (int i = 0; i < tl.size(); i++) begin
      @(negedge clk);
      check("ctrl", 32'(ctrl_obs), 32'(tl[i].ctrl));
      if (tl[i].chk_addr) begin
        check("a_out", a_out, addr);
        check("siz", 32'(siz_out), 32'(siz));
        check("rnw", 32'(rnw_out), 32'(rnw));
      end
      if (tl[i].chk_dout) check("d_out", d_out, wdata);
      if (tl[i].chk_end || i == tl.size() - 1) check("err", 32'(err), 32'(exp_err));
      if (tl[i].chk_end && exp_rd_valid) check("rdata", rdata, exp_rdata);
      // client keeps fiddling with the request lines while busy; must be ignored
      req = (i < tl.size() - 1) ? 1'($urandom_range(1)) : 1'b0;
      req_addr = $urandom; req_wdata = $urandom; req_rnw = 1'($urandom_range(1));
      bgn = tl[i].bgn; bbn_in = tl[i].bbn_in; tackn = tl[i].tackn; tean = tl[i].tean;
      d_in = tl[i].din;
    end
    bgn = 1; bbn_in = 1; tackn = 1; tean = 1;
  endtask

  task automatic set_att(input int n, input int gv, input int wv, input int tv);
    g[n] = gv; w[n] = wv; tm[n] = tv;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst ctrl", 32'(ctrl_obs), 32'(V_IDLE));
    check("rst err", 32'(err), 0);
    check("rst rdata", rdata, 0);
    check("rst a/d", a_out | d_out, 0);
    check("rst siz/rnw", 32'({siz_out, rnw_out}), 32'(3'b001));
    check("tt/tm", 32'({tt_out, tm_out}), 32'(5'b00001));
    rst_n = 1;

    set_att(0, 0, 0, T_TACK);
    run(1, 32'h00F80000, 32'h0, 2'b00);
    check("read data", rdata, exp_rdata);

    set_att(0, 5, 3, T_TACK);
    run(0, 32'h00DFF180, 32'h00000FFF, 2'b10);

    set_att(0, 1, 2, T_TEA);
    run(1, 32'h12345678, 32'h0, 2'b01);

    for (int a = 0; a < 4; a++) set_att(a, 1, 1, T_BOTH);
    run(0, 32'hA5A50000, 32'hDEADBEEF, 2'b11);
    for (int a = 0; a < 3; a++) set_att(a, 0, 0, T_BOTH);
    set_att(3, 0, 0, T_TACK);
    run(1, 32'h0000C0DE, 32'h0, 2'b00);

    set_att(0, 0, 20, T_TACK);
    run(1, 32'h00400000, 32'h0, 2'b00);
    set_att(0, 0, TMO - 1, T_TACK);
    run(1, 32'h00400004, 32'h0, 2'b00);

    // reset in the middle of a write DATA phase
    @(negedge clk);
    req = 1; req_rnw = 0; req_addr = 32'h00E00000; req_wdata = 32'h55AA55AA;
    @(negedge clk); req = 0; bgn = 0; bbn_in = 1;
    @(negedge clk); bgn = 1;
    @(negedge clk);
    check("pre-rst data", 32'(ctrl_obs), 32'(V_DATAW));
    rst_n = 0;
    @(negedge clk);
    check("mid rst ctrl", 32'(ctrl_obs), 32'(V_IDLE));
    rst_n = 1;
    @(negedge clk);
    check("post rst ctrl", 32'(ctrl_obs), 32'(V_IDLE));

    for (int n = 0; n < 16; n++) begin
      int nr;
      nr = $urandom_range(0, 3);
      for (int a = 0; a < 4; a++) set_att(a, $urandom_range(0, 4), $urandom_range(0, 4), T_BOTH);
      tm[nr] = $urandom_range(0, 2);
      if (tm[nr] == T_BOTH && nr < RMAX) tm[nr] = T_TACK;
      run(1'($urandom_range(1)), $urandom, $urandom, 2'($urandom_range(3)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
